// File: rtl/cachev3.sv
// Set-associative write-back, write-allocate data cache with round-robin
// replacement and a req/ack handshake to the backing memory.
module cachev3 #(
    parameter int SETS = 4,
    parameter int WAYS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cache_enable_i,
    input  logic        write_enable_i,
    input  logic        byte_op_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        hit_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 30 - INDEX_W;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
    state_t state, state_next;

    logic [SETS-1:0][WAYS-1:0]  valid, dirty;
    logic [SETS-1:0][WAY_W-1:0] victim_ptr;
    logic [TAG_W-1:0]           tag_mem  [SETS][WAYS];
    logic [31:0]                data_mem [SETS][WAYS];
    logic [WAY_W-1:0]           victim_way;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         offset;
    assign index  = address_i[2+INDEX_W-1:2];
    assign tag    = address_i[31:2+INDEX_W];
    assign offset = address_i[1:0];

    logic             hit, found_invalid;
    logic [WAY_W-1:0] hit_way, invalid_way, miss_way;
    logic [31:0]      hit_data;
    logic [7:0]       hit_byte;

    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        found_invalid = 1'b0;
        invalid_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid[index][WAY_W'(w)] && tag_mem[index][WAY_W'(w)] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found_invalid && !valid[index][WAY_W'(w)]) begin
                found_invalid = 1'b1;
                invalid_way   = WAY_W'(w);
            end
        end
        miss_way = found_invalid ? invalid_way : victim_ptr[index];
        hit_data = data_mem[index][hit_way];
        hit_byte = hit_data[{offset, 3'b000} +: 8];
    end

    logic store_hit, start_miss, install;

    always_comb begin
        state_next  = state;
        hit_o       = 1'b0;
        stall_o     = 1'b0;
        read_data_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        store_hit   = 1'b0;
        start_miss  = 1'b0;
        install     = 1'b0;
        case (state)
            IDLE: begin
                if (cache_enable_i) begin
                    if (hit) begin
                        hit_o       = 1'b1;
                        read_data_o = byte_op_i ? {24'b0, hit_byte} : hit_data;
                        store_hit   = write_enable_i;
                    end else begin
                        // The core may already be requesting while reset is held.
                        stall_o    = ~rst_i;
                        start_miss = 1'b1;
                        state_next = (valid[index][miss_way] && dirty[index][miss_way])
                                     ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_mem[index][victim_way], index, 2'b00};
                mem_wdata_o = data_mem[index][victim_way];
                if (mem_ack_i) state_next = REFILL;
            end
            REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {address_i[31:2], 2'b00};
                if (mem_ack_i) begin
                    install    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            victim_ptr <= '0;
            victim_way <= '0;
        end else begin
            state <= state_next;
            if (start_miss) victim_way <= miss_way;
            if (store_hit) dirty[index][hit_way] <= 1'b1;
            if (install) begin
                valid[index][victim_way] <= 1'b1;
                dirty[index][victim_way] <= 1'b0;
                if (WAYS > 1 && victim_way == victim_ptr[index])
                    victim_ptr[index] <= victim_ptr[index] + 1'b1;
            end
        end
    end

    // Data and tag arrays survive reset; only the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            if (byte_op_i) data_mem[index][hit_way][{offset, 3'b000} +: 8] <= write_data_i[7:0];
            else           data_mem[index][hit_way] <= write_data_i;
        end
        if (install) begin
            data_mem[index][victim_way] <= mem_rdata_i;
            tag_mem[index][victim_way]  <= tag;
        end
    end
endmodule

// File: tb/tb_cachev3.sv
// Self-checking bench for cachev3: directed scenarios plus randomized
// accesses against a transaction-level cache/memory model.
module tb_cachev3;
    localparam int SETS = 4;
    localparam int WAYS = 2;
    localparam int IW   = 2;

    logic        clk, rst_i, cache_enable_i, write_enable_i, byte_op_i;
    logic [31:0] address_i, write_data_i, read_data_o;
    logic        hit_o, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    cachev3 #(.SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk), .rst_i(rst_i), .cache_enable_i(cache_enable_i),
        .write_enable_i(write_enable_i), .byte_op_i(byte_op_i),
        .address_i(address_i), .write_data_i(write_data_i),
        .read_data_o(read_data_o), .hit_o(hit_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    txn_t txq[$];

    logic [31:0] mem [bit [31:0]];
    int forced_lat = 0;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Backing memory: acks after a latency, logs every completed transaction.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack_i = 0;
        mem_rdata_i = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 0;
            if (rst_i) cnt = 0;
            else if (mem_req_o) begin
                if (cnt == 0) cnt = (forced_lat != 0) ? forced_lat : int'($urandom_range(1, 4));
                cnt--;
                if (cnt == 0) begin
                    mem_ack_i = 1;
                    mem_rdata_i = mem_peek(mem_addr_o);
                    txq.push_back('{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o});
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                end
            end
        end
    end

    // Reference model: per-set lines plus round-robin pointer.
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    logic [31:0] m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_ptr   [SETS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endfunction

    function automatic void model_access(input bit we, input bit bt, input logic [31:0] addr,
                                         input logic [31:0] wd, output bit e_hit, output bit e_wb,
                                         output logic [31:0] e_wb_addr, output logic [31:0] e_wb_data,
                                         output logic [31:0] e_rd);
        int s, way, off;
        logic [31:0] t;
        s = int'((addr >> 2) % SETS);
        t = addr >> (2 + IW);
        off = int'(addr % 4);
        way = -1;
        e_wb = 0;
        e_wb_addr = 0;
        e_wb_data = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        e_hit = (way >= 0);
        if (!e_hit) begin
            way = m_ptr[s];
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[s][w]) way = w;
            if (m_valid[s][way] && m_dirty[s][way]) begin
                e_wb = 1;
                e_wb_addr = (m_tag[s][way] << (2 + IW)) | (s << 2);
                e_wb_data = m_data[s][way];
            end
            m_valid[s][way] = 1;
            m_dirty[s][way] = 0;
            m_tag[s][way]   = t;
            m_data[s][way]  = mem_peek(addr & ~32'h3);
            if (way == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        if (we) begin
            if (bt) m_data[s][way][8*off +: 8] = wd[7:0];
            else    m_data[s][way] = wd;
            m_dirty[s][way] = 1;
        end
        e_rd = bt ? ((m_data[s][way] >> (8 * off)) & 32'hFF) : m_data[s][way];
    endfunction

    task automatic run_access(input bit we, input bit bt, input logic [31:0] addr, input logic [31:0] wd,
                              output bit first_hit, output bit final_hit, output int cycles,
                              output logic [31:0] rd);
        @(negedge clk);
        cache_enable_i = 1; write_enable_i = we; byte_op_i = bt;
        address_i = addr; write_data_i = wd;
        #1;
        first_hit = hit_o;
        cycles = 1;
        while (stall_o && cycles < 200) begin
            @(negedge clk); #1;
            cycles++;
        end
        final_hit = hit_o;
        rd = read_data_o;
        @(posedge clk); #1;
        cache_enable_i = 0;
    endtask

    bit fh, lh, e_hit, e_wb;
    int cyc;
    logic [31:0] rd, e_wa, e_wd, e_rd;

    task automatic test_reset();
        rst_i = 1; cache_enable_i = 1; write_enable_i = 0; byte_op_i = 0;
        address_i = 0; write_data_i = 0;
        model_clear();
        @(negedge clk); #1;
        checks++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req_o); else passed++;
        checks++; if (mem_we_o !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", mem_we_o); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else passed++;
        checks++; if (hit_o !== 1'b0) $display("FAIL rst_hit: got %b want 0", hit_o); else passed++;
        checks++; if (read_data_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", read_data_o); else passed++;
        cache_enable_i = 0;
        @(negedge clk);
        rst_i = 0;
        #1;
        checks++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL post_rst_idle: got stall=%b req=%b want 0 0", stall_o, mem_req_o); else passed++;
    endtask

    task automatic test_refill_latency();
        mem[32'h0] = 32'h11223344;
        forced_lat = 3;
        model_access(0, 0, 32'h0, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        txq.delete();
        run_access(0, 0, 32'h0, 0, fh, lh, cyc, rd);
        forced_lat = 0;
        checks++; if (fh !== 1'b0) $display("FAIL refill_first_hit: got %b want 0", fh); else passed++;
        checks++; if (cyc != 5) $display("FAIL refill_cycles: got %0d want 5", cyc); else passed++;
        checks++; if (txq.size() != 1) $display("FAIL refill_txn_count: got %0d want 1", txq.size()); else passed++;
        if (txq.size() > 0) begin
            checks++; if (txq[0].we !== 1'b0 || txq[0].addr !== 32'h0)
                $display("FAIL refill_txn: got we=%b addr=%h want 0 00000000", txq[0].we, txq[0].addr); else passed++;
        end
        checks++; if (lh !== 1'b1) $display("FAIL refill_then_hit: got %b want 1", lh); else passed++;
        checks++; if (rd !== 32'h11223344) $display("FAIL refill_rdata: got %h want 11223344", rd); else passed++;
    endtask

    task automatic test_store_hit();
        model_access(1, 0, 32'h10, 32'hDEADBEEF, e_hit, e_wb, e_wa, e_wd, e_rd);
        txq.delete();
        run_access(1, 0, 32'h10, 32'hDEADBEEF, fh, lh, cyc, rd);
        checks++; if (fh !== 1'b0) $display("FAIL store_miss: got hit=%b want 0", fh); else passed++;
        checks++; if (txq.size() != 1) $display("FAIL store_txn_count: got %0d want 1", txq.size()); else passed++;
        if (txq.size() > 0) begin
            checks++; if (txq[0].we !== 1'b0 || txq[0].addr !== 32'h10)
                $display("FAIL store_refill: got we=%b addr=%h want 0 00000010", txq[0].we, txq[0].addr); else passed++;
        end
        model_access(0, 0, 32'h10, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        txq.delete();
        run_access(0, 0, 32'h10, 0, fh, lh, cyc, rd);
        checks++; if (fh !== 1'b1) $display("FAIL store_load_hit: got %b want 1", fh); else passed++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL store_load_data: got %h want deadbeef", rd); else passed++;
        checks++; if (txq.size() != 0) $display("FAIL store_no_mem_write: got %0d txns want 0", txq.size()); else passed++;
    endtask

    task automatic test_byte_lanes();
        txq.delete();
        model_access(1, 1, 32'h2, 32'h000000AB, e_hit, e_wb, e_wa, e_wd, e_rd);
        run_access(1, 1, 32'h2, 32'h000000AB, fh, lh, cyc, rd);
        checks++; if (fh !== 1'b1) $display("FAIL byte_store_hit: got %b want 1", fh); else passed++;
        model_access(0, 1, 32'h2, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        run_access(0, 1, 32'h2, 0, fh, lh, cyc, rd);
        checks++; if (rd !== 32'h000000AB) $display("FAIL byte_load: got %h want 000000ab", rd); else passed++;
        model_access(0, 0, 32'h0, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        run_access(0, 0, 32'h0, 0, fh, lh, cyc, rd);
        checks++; if (rd !== 32'h11AB3344) $display("FAIL byte_merge_word: got %h want 11ab3344", rd); else passed++;
        checks++; if (txq.size() != 0) $display("FAIL byte_no_mem: got %0d txns want 0", txq.size()); else passed++;
    endtask

    task automatic test_writeback();
        model_access(0, 0, 32'h20, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        txq.delete();
        run_access(0, 0, 32'h20, 0, fh, lh, cyc, rd);
        checks++; if (txq.size() != 2) $display("FAIL wb1_txn_count: got %0d want 2", txq.size()); else passed++;
        if (txq.size() == 2) begin
            checks++; if (txq[0].we !== 1'b1 || txq[0].addr !== 32'h0 || txq[0].wdata !== 32'h11AB3344)
                $display("FAIL wb1_victim: got we=%b addr=%h data=%h want 1 00000000 11ab3344",
                         txq[0].we, txq[0].addr, txq[0].wdata); else passed++;
            checks++; if (txq[1].we !== 1'b0 || txq[1].addr !== 32'h20)
                $display("FAIL wb1_refill: got we=%b addr=%h want 0 00000020", txq[1].we, txq[1].addr); else passed++;
        end
        checks++; if (rd !== mem_peek(32'h20)) $display("FAIL wb1_rdata: got %h want %h", rd, mem_peek(32'h20)); else passed++;
        model_access(0, 0, 32'h30, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        txq.delete();
        run_access(0, 0, 32'h30, 0, fh, lh, cyc, rd);
        checks++; if (txq.size() != 2) $display("FAIL wb2_txn_count: got %0d want 2", txq.size()); else passed++;
        if (txq.size() == 2) begin
            checks++; if (txq[0].we !== 1'b1 || txq[0].addr !== 32'h10 || txq[0].wdata !== 32'hDEADBEEF)
                $display("FAIL wb2_victim: got we=%b addr=%h data=%h want 1 00000010 deadbeef",
                         txq[0].we, txq[0].addr, txq[0].wdata); else passed++;
            checks++; if (txq[1].we !== 1'b0 || txq[1].addr !== 32'h30)
                $display("FAIL wb2_refill: got we=%b addr=%h want 0 00000030", txq[1].we, txq[1].addr); else passed++;
        end
    endtask

    task automatic test_disabled();
        txq.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cache_enable_i = 0; write_enable_i = 1'($urandom); byte_op_i = 1'($urandom);
            address_i = $urandom; write_data_i = $urandom;
            #1;
            checks++; if (mem_req_o !== 1'b0 || hit_o !== 1'b0 || stall_o !== 1'b0 || read_data_o !== 32'h0)
                $display("FAIL disabled_quiet: got req=%b hit=%b stall=%b rdata=%h want 0 0 0 0",
                         mem_req_o, hit_o, stall_o, read_data_o); else passed++;
        end
        model_access(0, 0, 32'h20, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        run_access(0, 0, 32'h20, 0, fh, lh, cyc, rd);
        checks++; if (fh !== 1'b1 || rd !== e_rd)
            $display("FAIL disabled_contents: got hit=%b rdata=%h want 1 %h", fh, rd, e_rd); else passed++;
        checks++; if (txq.size() != 0) $display("FAIL disabled_no_mem: got %0d txns want 0", txq.size()); else passed++;
    endtask

    task automatic test_random();
        bit we, bt;
        logic [31:0] addr, wd;
        int idx;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom); bt = 1'($urandom);
            addr = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            wd = $urandom;
            model_access(we, bt, addr, wd, e_hit, e_wb, e_wa, e_wd, e_rd);
            txq.delete();
            run_access(we, bt, addr, wd, fh, lh, cyc, rd);
            checks++; if (cyc >= 200) $display("FAIL rnd_timeout: got %0d cycles want <200", cyc); else passed++;
            checks++; if (fh !== e_hit) $display("FAIL rnd_hit @%h: got %b want %b", addr, fh, e_hit); else passed++;
            checks++; if (lh !== 1'b1) $display("FAIL rnd_final_hit @%h: got %b want 1", addr, lh); else passed++;
            if (!we) begin
                checks++; if (rd !== e_rd) $display("FAIL rnd_rdata @%h: got %h want %h", addr, rd, e_rd); else passed++;
            end
            checks++; if (txq.size() != int'(e_wb) + int'(!e_hit))
                $display("FAIL rnd_txn_count @%h: got %0d want %0d", addr, txq.size(), int'(e_wb) + int'(!e_hit));
            else begin
                passed++;
                idx = 0;
                if (e_wb) begin
                    checks++; if (txq[0].we !== 1'b1 || txq[0].addr !== e_wa || txq[0].wdata !== e_wd)
                        $display("FAIL rnd_wb: got we=%b addr=%h data=%h want 1 %h %h",
                                 txq[0].we, txq[0].addr, txq[0].wdata, e_wa, e_wd); else passed++;
                    idx = 1;
                end
                if (!e_hit) begin
                    checks++; if (txq[idx].we !== 1'b0 || txq[idx].addr !== (addr & ~32'h3))
                        $display("FAIL rnd_refill: got we=%b addr=%h want 0 %h",
                                 txq[idx].we, txq[idx].addr, addr & ~32'h3); else passed++;
                end
            end
        end
    endtask

    task automatic test_reset_midrefill();
        forced_lat = 50;
        txq.delete();
        @(negedge clk);
        cache_enable_i = 1; write_enable_i = 0; byte_op_i = 0; address_i = 32'h48; write_data_i = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mem_req_o !== 1'b1) $display("FAIL abort_req_before: got %b want 1", mem_req_o); else passed++;
        #2 rst_i = 1;
        #1;
        checks++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL abort_async_drop: got req=%b stall=%b want 0 0", mem_req_o, stall_o); else passed++;
        @(negedge clk);
        cache_enable_i = 0;
        @(negedge clk);
        rst_i = 0;
        forced_lat = 2;
        model_clear();
        checks++; if (txq.size() != 0) $display("FAIL abort_no_ack: got %0d txns want 0", txq.size()); else passed++;
        model_access(0, 0, 32'h48, 0, e_hit, e_wb, e_wa, e_wd, e_rd);
        run_access(0, 0, 32'h48, 0, fh, lh, cyc, rd);
        checks++; if (fh !== 1'b0) $display("FAIL abort_remiss: got hit=%b want 0", fh); else passed++;
        checks++; if (rd !== e_rd) $display("FAIL abort_reload_data: got %h want %h", rd, e_rd); else passed++;
        checks++; if (txq.size() != 1) $display("FAIL abort_reload_txns: got %0d want 1", txq.size()); else passed++;
        forced_lat = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_refill_latency();
        test_store_hit();
        test_byte_lanes();
        test_writeback();
        test_disabled();
        test_random();
        test_reset_midrefill();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
